// File: rtl/serializer_pkg.sv
// Shared types and defaults for the width serializer (RMII transmit configuration).
// Optional underrun flag in width_serializer is enabled by WIDTH_SERIALIZER_UNDERRUN_EN.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } ser_state_t;

    localparam int RMII_IN_W  = 8;
    localparam int RMII_OUT_W = 2;

    // Gap counter must hold IFG_CYCLES-1 but never collapse to zero bits.
    function automatic int gap_cnt_w(input int ifg);
        return (ifg > 0) ? $clog2(ifg + 1) : 1;
    endfunction

endpackage

// File: rtl/ser_sync_fifo.sv
// Small synchronous FIFO with combinational head read; pointers carry an extra wrap bit.
// Push while full is dropped even if a pop happens on the same edge.
module ser_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/width_serializer.sv
// Wide-to-narrow valid/ready serializer with input FIFO, frame-last tagging and inter-frame gap.
// Define WIDTH_SERIALIZER_UNDERRUN_EN to add the sticky mid-frame underrun output.
module width_serializer
    import serializer_pkg::*;
#(
    parameter int IN_W       = RMII_IN_W,
    parameter int OUT_W      = RMII_OUT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 1,
    parameter int IFG_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [IN_W-1:0]  axiid,
    input  logic             axiilast,
    output logic             axiir,
    output logic             axiov,
    output logic [OUT_W-1:0] axiod,
    output logic             axiolast,
    input  logic             axior
`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
    ,
    output logic             underrun
`endif
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CW    = $clog2(RATIO);
    localparam int GW    = gap_cnt_w(IFG_CYCLES);
    localparam logic [CW-1:0] LAST_SLICE = CW'(RATIO - 1);
    localparam bit HAS_GAP = (IFG_CYCLES > 0);

    ser_state_t       r_state;
    logic             r_vld;
    logic             r_last;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gap;
    logic [IN_W-1:0]  r_sh;

    logic             w_full;
    logic             w_empty;
    logic [IN_W:0]    w_head;
    logic             w_xfer;
    logic             w_end;
    logic             w_load;
    logic [OUT_W-1:0] w_slice;

    ser_sync_fifo #(
        .WIDTH (IN_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (axiiv),
        .i_pop   (w_load),
        .i_din   ({axiilast, axiid}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign axiir    = !w_full;
    assign w_xfer   = r_vld && axior;
    assign w_end    = w_xfer && (r_cnt == LAST_SLICE);
    assign w_slice  = (LSB_FIRST != 0) ? r_sh[OUT_W-1:0] : r_sh[IN_W-1 -: OUT_W];
    assign axiov    = r_vld;
    assign axiod    = r_vld ? w_slice : '0;
    assign axiolast = r_vld && r_last && (r_cnt == LAST_SLICE);

    // The gap's final cycle loads directly so a waiting word sees exactly IFG_CYCLES idle cycles.
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            IDLE:    w_load = !w_empty;
            SHIFT:   w_load = w_end && !(r_last && HAS_GAP) && !w_empty;
            GAP:     w_load = (r_gap == '0) && !w_empty;
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_load)
            r_sh <= w_head[IN_W-1:0];
        else if (w_xfer)
            r_sh <= (LSB_FIRST != 0) ? (r_sh >> OUT_W) : (r_sh << OUT_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= SHIFT;
                        r_vld   <= 1'b1;
                        r_last  <= w_head[IN_W];
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (w_xfer) begin
                        if (r_cnt == LAST_SLICE) begin
                            if (w_load) begin
                                r_last <= w_head[IN_W];
                                r_cnt  <= '0;
                            end else if (r_last && HAS_GAP) begin
                                r_state <= GAP;
                                r_vld   <= 1'b0;
                                r_gap   <= GW'(IFG_CYCLES - 1);
                            end else begin
                                r_state <= IDLE;
                                r_vld   <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        if (w_load) begin
                            r_state <= SHIFT;
                            r_vld   <= 1'b1;
                            r_last  <= w_head[IN_W];
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_underrun <= 1'b0;
        else if (w_end && !r_last && w_empty)
            r_underrun <= 1'b1;
    end

    assign underrun = r_underrun;
`endif

endmodule

// File: tb/tb_width_serializer.sv
// Directed bench for width_serializer: three instances (defaults, MSB-first, 3-cycle gap).
// Covers WIDTH_SERIALIZER_UNDERRUN_EN when that macro is defined for the build.
module tb_width_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] iv;
    logic [2:0] il;
    logic [2:0] orr;
    logic [7:0] id [3];
    wire  [2:0] ir;
    wire  [2:0] ov;
    wire  [2:0] ol;
    wire  [5:0] od_all;
`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
    wire  [2:0] un;
`endif

    int errors = 0;
    int checks = 0;

    logic       acc;
    logic       xfer;
    int         k;
    int         got;
    int         j;
    int         ncyc;
    logic [7:0] cur;
    logic [7:0] w [6];

    always #5 clk = ~clk;

    width_serializer u_def (
        .clk(clk), .rst(rst), .axiiv(iv[0]), .axiid(id[0]), .axiilast(il[0]), .axiir(ir[0]),
        .axiov(ov[0]), .axiod(od_all[1:0]), .axiolast(ol[0]), .axior(orr[0])
`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
        , .underrun(un[0])
`endif
    );

    width_serializer #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .axiiv(iv[1]), .axiid(id[1]), .axiilast(il[1]), .axiir(ir[1]),
        .axiov(ov[1]), .axiod(od_all[3:2]), .axiolast(ol[1]), .axior(orr[1])
`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
        , .underrun(un[1])
`endif
    );

    width_serializer #(.IFG_CYCLES(3)) u_gap (
        .clk(clk), .rst(rst), .axiiv(iv[2]), .axiid(id[2]), .axiilast(il[2]), .axiir(ir[2]),
        .axiov(ov[2]), .axiod(od_all[5:4]), .axiolast(ol[2]), .axior(orr[2])
`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
        , .underrun(un[2])
`endif
    );

    function automatic logic [1:0] odx(input int i);
        return od_all[i*2 +: 2];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word into an idle instance and check its four slices and the idle after.
    task automatic send_word(input int i, input logic [7:0] wd, input logic lst,
                             input logic [1:0] s0, input logic [1:0] s1,
                             input logic [1:0] s2, input logic [1:0] s3, input string tag);
        logic [1:0] s [4];
        s = '{s0, s1, s2, s3};
        iv[i] = 1'b1;
        id[i] = wd;
        il[i] = lst;
        step();
        iv[i] = 1'b0;
        step();
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("%s_v%0d", tag, n), ov[i], 1'b1);
            chk($sformatf("%s_d%0d", tag, n), odx(i), s[n]);
            chk($sformatf("%s_last%0d", tag, n), ol[i], (n == 3) ? lst : 1'b0);
            if (n < 3) step();
        end
        step();
        chk($sformatf("%s_idle", tag), ov[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iv  = '0;
        il  = '0;
        orr = '1;
        for (int i = 0; i < 3; i++) id[i] = 8'h00;
        w = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'hE1, 8'h78};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ov%0d", i), ov[i], 1'b0);
            chk($sformatf("rst_od%0d", i), odx(i), 2'b00);
            chk($sformatf("rst_ol%0d", i), ol[i], 1'b0);
            chk($sformatf("rst_ir%0d", i), ir[i], 1'b1);
        end

        // Single last-tagged word, LSB first.
        send_word(0, 8'hF3, 1'b1, 2'b11, 2'b00, 2'b11, 2'b11, "t1");

        // Bit order.
        send_word(1, 8'h26, 1'b1, 2'b00, 2'b10, 2'b01, 2'b10, "t2msb");
        send_word(0, 8'h26, 1'b1, 2'b10, 2'b01, 2'b10, 2'b00, "t2lsb");
`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
        chk("un_clear_after_frames", un[0], 1'b0);
`endif

        // Back-to-back words, then a 3-cycle gap with a word queued during it.
        iv[2] = 1'b1; id[2] = 8'hF3; il[2] = 1'b0;
        step();
        id[2] = 8'h26; il[2] = 1'b1;
        step();
        iv[2] = 1'b0;
        begin
            logic [1:0] e [8];
            e = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b00};
            for (int n = 0; n < 8; n++) begin
                chk($sformatf("t3_v%0d", n), ov[2], 1'b1);
                chk($sformatf("t3_d%0d", n), odx(2), e[n]);
                chk($sformatf("t3_last%0d", n), ol[2], (n == 7) ? 1'b1 : 1'b0);
                step();
            end
        end
        chk("t3_gap0", ov[2], 1'b0);
        chk("t3_gap_ir", ir[2], 1'b1);
        iv[2] = 1'b1; id[2] = 8'h9C; il[2] = 1'b1;
        step();
        iv[2] = 1'b0;
        chk("t3_gap1", ov[2], 1'b0);
        step();
        chk("t3_gap2", ov[2], 1'b0);
        step();
        chk("t3_w3_v0", ov[2], 1'b1);
        chk("t3_w3_d0", odx(2), 2'b00);
        step();
        chk("t3_w3_d1", odx(2), 2'b11);
        step();
        chk("t3_w3_d2", odx(2), 2'b01);
        step();
        chk("t3_w3_d3", odx(2), 2'b10);
        chk("t3_w3_last", ol[2], 1'b1);
        step();
        chk("t3_w3_gap", ov[2], 1'b0);
        repeat (4) step();

        // Backpressure: fill with axior low, then drain in order.
        orr[0] = 1'b0;
        k = 0;
        iv[0] = 1'b1; id[0] = w[0]; il[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            acc = ir[0] && iv[0];
            step();
            if (acc) begin
                k++;
                if (k < 6) begin
                    id[0] = w[k];
                    il[0] = (k == 5);
                end else begin
                    iv[0] = 1'b0;
                end
            end
        end
        chk("t4_accepts", k, 5);
        chk("t4_ir_full", ir[0], 1'b0);
        chk("t4_stall_v", ov[0], 1'b1);
        chk("t4_stall_d", odx(0), 2'b01);
        repeat (3) step();
        chk("t4_hold_d", odx(0), 2'b01);
        chk("t4_hold_last", ol[0], 1'b0);

        orr[0] = 1'b1;
        got = 0; j = 0; cur = 8'h00; ncyc = 0;
        while (got < 6 && ncyc < 60) begin
            acc  = ir[0] && iv[0];
            xfer = ov[0] && orr[0];
            if (xfer) begin
                cur = cur | (8'(odx(0)) << (2 * j));
                if (j == 3) begin
                    chk($sformatf("t4_word%0d", got), cur, w[got]);
                    chk($sformatf("t4_last%0d", got), ol[0], (got == 5) ? 1'b1 : 1'b0);
                    got++;
                    j = 0;
                    cur = 8'h00;
                end else begin
                    j++;
                end
            end
            step();
            ncyc++;
            if (acc) begin
                k++;
                iv[0] = 1'b0;
            end
        end
        chk("t4_words", got, 6);
        chk("t4_gapless_cycles", ncyc, 24);
        chk("t4_drained", ov[0], 1'b0);

        // Reset during the second slice flushes FIFO and partial word.
        iv[0] = 1'b1; id[0] = 8'hB4; il[0] = 1'b0;
        step();
        id[0] = 8'h5A;
        step();
        iv[0] = 1'b0;
        chk("t5_d0", odx(0), 2'b00);
        step();
        chk("t5_d1", odx(0), 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ov", ov[0], 1'b0);
        chk("t5_rst_od", odx(0), 2'b00);
        chk("t5_rst_ol", ol[0], 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("t5_flushed0", ov[0], 1'b0);
        step();
        chk("t5_flushed1", ov[0], 1'b0);
        send_word(0, 8'hC6, 1'b1, 2'b10, 2'b01, 2'b00, 2'b11, "t5");

`ifdef WIDTH_SERIALIZER_UNDERRUN_EN
        chk("un_pre", un[0], 1'b0);
        iv[0] = 1'b1; id[0] = 8'h11; il[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        repeat (6) step();
        chk("un_set", un[0], 1'b1);
        repeat (3) step();
        chk("un_sticky", un[0], 1'b1);
        chk("un_idle", ov[0], 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("un_rst", un[0], 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
